// File: rtl/pdm_decimator_if.sv
// PDM input / PCM output bundle for the sinc3 decimator.
// The source side drives the PDM bit stream and consumes the PCM samples.
interface pdm_decimator_if #(
  parameter int DATA = 12
);
  logic                   pdm_in;
  logic                   pdm_valid;
  logic signed [DATA-1:0] dout;
  logic                   dout_valid;

  modport master (
    output pdm_in,
    output pdm_valid,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  pdm_in,
    input  pdm_valid,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream back into signed PCM.
// The output code uses the DAC encoding: ones-density p maps to 4096*p - 2048.
//
// warm-up FSM
//   state | meaning
//   WARM0 | no decimation event seen since reset
//   WARM1 | one event seen, comb history still filling
//   WARM2 | two events seen, comb history still filling
//   RUN   | comb history valid, every event strobes dout_valid
module pdm_decimator #(
  parameter int DATA       = 12,
  parameter int LOG2_DECIM = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  pdm_decimator_if.slave pdm
);

  localparam int W     = 3 * LOG2_DECIM + 2;
  localparam int SHIFT = 3 * LOG2_DECIM + 1 - DATA;

  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;
  localparam logic [LOG2_DECIM-1:0] CNT_ONE  = LOG2_DECIM'(1);

  localparam logic signed [DATA-1:0] Y_MAX = {1'b0, {(DATA-1){1'b1}}};
  localparam logic signed [DATA-1:0] Y_MIN = {1'b1, {(DATA-1){1'b0}}};

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    WARM2 = 2'd2,
    RUN   = 2'd3
  } warm_state_t;

  warm_state_t r_state;
  warm_state_t w_state_nxt;
  logic        w_strobe;

  logic signed [W-1:0]    r_i1, r_i2, r_i3;
  logic signed [W-1:0]    r_d1, r_d2, r_d3;
  logic [LOG2_DECIM-1:0]  r_cnt;
  logic                   r_dec_tick;
  logic signed [DATA-1:0] r_dout;
  logic                   r_dout_valid;

  logic signed [W-1:0]    w_x;
  logic signed [W-1:0]    w_c1, w_c2, w_c3;
  logic signed [W-1:0]    w_c3_shr;
  logic signed [DATA:0]   w_y_wide;
  logic signed [DATA-1:0] w_y;

  // 1 -> +1, 0 -> -1, already sign-extended to W bits
  assign w_x = {{(W-1){~pdm.pdm_in}}, 1'b1};

  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  // After the shift only DATA+1 significant bits remain; clamp the extra one.
  assign w_c3_shr = w_c3 >>> SHIFT;
  assign w_y_wide = w_c3_shr[DATA:0];

  always_comb begin
    w_y = w_y_wide[DATA-1:0];
    if (!w_y_wide[DATA] && w_y_wide[DATA-1]) begin
      w_y = Y_MAX;
    end else if (w_y_wide[DATA] && !w_y_wide[DATA-1]) begin
      w_y = Y_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i1       <= '0;
      r_i2       <= '0;
      r_i3       <= '0;
      r_cnt      <= '0;
      r_dec_tick <= 1'b0;
    end else begin
      if (pdm.pdm_valid) begin
        r_i1  <= r_i1 + w_x;
        r_i2  <= r_i2 + r_i1;
        r_i3  <= r_i3 + r_i2;
        r_cnt <= r_cnt + CNT_ONE;
      end
      r_dec_tick <= pdm.pdm_valid && (r_cnt == CNT_LAST);
    end
  end

  // Comb sees the pre-update i3 even if a new bit is accepted this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d1         <= '0;
      r_d2         <= '0;
      r_d3         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (r_dec_tick) begin
        r_d1   <= r_i3;
        r_d2   <= w_c1;
        r_d3   <= w_c2;
        r_dout <= w_y;
      end
      r_dout_valid <= w_strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= WARM0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = 1'b0;
    case (r_state)
      WARM0: if (r_dec_tick) w_state_nxt = WARM1;
      WARM1: if (r_dec_tick) w_state_nxt = WARM2;
      WARM2: if (r_dec_tick) w_state_nxt = RUN;
      RUN:   w_strobe = r_dec_tick;
      default: w_state_nxt = WARM0;
    endcase
  end

  assign pdm.dout       = r_dout;
  assign pdm.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: the stimulus driver queues the value and
// cycle of every strobe it expects, a negedge monitor pops and compares.
module tb_pdm_decimator;

  localparam int DATA = 12;
  localparam int L    = 6;
  localparam int R    = 64;

  typedef struct {
    int val;
    int tol;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pdm_decimator_if #(.DATA(DATA)) bus ();

  pdm_decimator #(.DATA(DATA), .LOG2_DECIM(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pdm   (bus)
  );

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      int   act;
      int   diff;
      exp_t e;
      act = bus.dout;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: dout=%0d at cycle %0d, required no strobe", act, cyc);
      end else begin
        e = sb.pop_front();
        diff = act - e.val;
        if (diff < 0) diff = -diff;
        if (diff > e.tol) begin
          errors++;
          $display("FAIL dout_value: got %0d at cycle %0d, required %0d +/- %0d", act, cyc, e.val, e.tol);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe_cycle: got cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    int d;
    d = bus.dout;
    checks++;
    if (d != 0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: dout=%0d dout_valid=%b, required dout=0 dout_valid=0", name, d, bus.dout_valid);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pdm_in = 1'b0;
    bus.pdm_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic flush(input string name);
    bus.pdm_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_strobes: %0d outstanding, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating, 3: first-order DAC of din
  task automatic stream(input int mode, input int nbits, input int vper,
                        input int din, input int rst_at);
    int         frame_bits;
    int         total;
    int         k;
    bit         rst_done;
    logic       b;
    logic [12:0] sdsum;
    logic [11:0] sdacc;
    exp_t       e;
    frame_bits = 0;
    total = 0;
    k = 0;
    rst_done = 1'b0;
    sdacc = '0;
    while (total < nbits) begin
      if (!rst_done && rst_at >= 0 && frame_bits == rst_at) begin
        rst_done = 1'b1;
        rst_n = 1'b0;
        bus.pdm_in = 1'b1;
        bus.pdm_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("mid_reset");
        frame_bits = 0;
      end
      b = 1'b0;
      if ((k % vper) == 0) begin
        case (mode)
          0: b = 1'b1;
          1: b = 1'b0;
          2: b = (frame_bits % 2) == 0;
          default: begin
            sdsum = {1'b0, sdacc} + 13'(din + 2048);
            b = sdsum[12];
            sdacc = sdsum[11:0];
          end
        endcase
        bus.pdm_in = b;
        bus.pdm_valid = 1'b1;
        frame_bits++;
        total++;
        if ((frame_bits % R) == 0 && (frame_bits / R) >= 4) begin
          case (mode)
            0: e.val = 2047;
            1: e.val = -2048;
            2: e.val = 0;
            default: e.val = din;
          endcase
          e.tol = (mode == 3) ? 4 : 0;
          e.cyc = cyc + 2;
          sb.push_back(e);
        end
      end else begin
        bus.pdm_in = 1'b0;
        bus.pdm_valid = 1'b0;
      end
      k++;
      @(posedge clk);
      #1;
    end
    bus.pdm_valid = 1'b0;
  endtask

  initial begin
    bus.pdm_in = 1'b0;
    bus.pdm_valid = 1'b0;
    @(posedge clk);
    #1;

    do_reset();
    stream(0, 7 * R, 1, 0, -1);
    flush("all_ones");

    do_reset();
    stream(1, 7 * R, 1, 0, -1);
    flush("all_zeros");

    do_reset();
    stream(2, 7 * R, 1, 0, -1);
    flush("alternating");

    do_reset();
    stream(3, 10 * R, 1, 1000, -1);
    flush("loop_p1000");

    do_reset();
    stream(3, 10 * R, 1, -1500, -1);
    flush("loop_m1500");

    do_reset();
    stream(3, 10 * R, 1, 0, -1);
    flush("loop_zero");

    do_reset();
    stream(0, 6 * R, 3, 0, -1);
    flush("sparse_valid");

    // reset lands when the frame counter reads 37, after two strobes
    do_reset();
    stream(0, 5 * R + 37 + 7 * R, 1, 0, 5 * R + 37);
    flush("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
